smmul_pipe: RTL and testbench



---
 rtl/smmul_pipe.sv | 176 +++++++++++++++++
 tb/tb_smmul_pipe.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/smmul_pipe.sv
`timescale 1ns/1ps
// smmul_pipe
// Pipelined sign-magnitude fixed-point multiplier with valid/ready flow
// control, saturation flag and a sticky saturation counter.
//
// Parameters:
//   BITSIZE  total word width (bit BITSIZE-1 = sign, rest = magnitude)
//   FRAC     fraction bits inside the magnitude
//   LAT      register stages from input transfer to out_valid (1..4)
//   CNTW     width of sat_count
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active low
//   in_valid     a/b presented this cycle
//   in_ready     block accepts operands this cycle (= !out_valid || out_ready)
//   a, b         sign-magnitude operands
//   out_valid    c/out_sat hold a result
//   out_ready    downstream accepts the result
//   c            sign-magnitude product
//   out_sat      product was saturated
//   clear_count  synchronous clear of sat_count (wins over an increment)
//   sat_count    saturated results transferred, sticks at all ones
//
// Build option:
//   SMMUL_ROUND_EN  defined: round half-up on the magnitude, rounding carry
//                   out of the magnitude field saturates.
//                   undefined: truncate the discarded fraction bits.
module smmul_pipe #(
  parameter int BITSIZE = 20,
  parameter int FRAC    = 11,
  parameter int LAT     = 3,
  parameter int CNTW    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BITSIZE-1:0] a,
  input  logic [BITSIZE-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITSIZE-1:0] c,
  output logic               out_sat,
  input  logic               clear_count,
  output logic [CNTW-1:0]    sat_count
);

  localparam int MW = BITSIZE - 1;   // magnitude width
  localparam int PW = 2 * MW;        // full product width
`ifdef SMMUL_ROUND_EN
  localparam int LO = FRAC - 1;      // keep the rounding bit
`else
  localparam int LO = FRAC;
`endif
  localparam int HW = PW - LO;       // retained upper product bits
  // With LAT >= 2 one stage is spent on the raw product, the rest carry
  // finished results; with LAT == 1 the whole computation feeds the output.
  localparam int RS = (LAT == 1) ? 1 : LAT - 1;

  // Upper part of the magnitude product; bits below LO never affect the result.
  function automatic logic [HW-1:0] mul_hi(input logic [MW-1:0] ma,
                                           input logic [MW-1:0] mb);
    logic [PW-1:0] p;
    p = PW'(ma) * PW'(mb);
    return HW'(p >> LO);
  endfunction

  // Normalise, optionally round, and saturate: returns {sat, magnitude}.
  function automatic logic [MW:0] sat_norm(input logic [HW-1:0] h);
    logic [MW:0] sum;
    logic        ovf;
`ifdef SMMUL_ROUND_EN
    ovf = |h[HW-1:MW+1];
    sum = {1'b0, h[MW:1]} + {{MW{1'b0}}, h[0]};
`else
    ovf = |h[HW-1:MW];
    sum = {1'b0, h[MW-1:0]};
`endif
    if (ovf || sum[MW]) begin
      return {1'b1, {MW{1'b1}}};
    end
    return {1'b0, sum[MW-1:0]};
  endfunction

  // Pack {sat, sign, magnitude}; a zero magnitude never carries a sign.
  function automatic logic [BITSIZE:0] sm_pack(input logic sign,
                                               input logic [MW:0] sm);
    logic [MW-1:0] mag;
    mag = sm[MW-1:0];
    return {sm[MW], sign & (|mag), mag};
  endfunction

  logic en;
  logic take;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign take     = in_valid && en;

  logic             res_vld;
  logic [BITSIZE:0] res_word;

  generate
    if (LAT == 1) begin : g_direct
      always_comb begin
        res_vld  = take;
        res_word = sm_pack(a[MW] ^ b[MW], sat_norm(mul_hi(a[MW-1:0], b[MW-1:0])));
      end
    end else begin : g_prod
      logic          vld_p0;
      logic          sign_p0;
      logic [HW-1:0] prod_p0;

      // ---- stage p0: raw magnitude product and sign ----
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p0 <= 1'b0;
        end else if (en) begin
          vld_p0 <= take;
        end
      end

      always_ff @(posedge clk) begin
        if (take) begin
          sign_p0 <= a[MW] ^ b[MW];
          prod_p0 <= mul_hi(a[MW-1:0], b[MW-1:0]);
        end
      end

      always_comb begin
        res_vld  = vld_p0;
        res_word = sm_pack(sign_p0, sat_norm(prod_p0));
      end
    end
  endgenerate

  // ---- result stages; the last one drives the outputs ----
  logic             vld_pr  [RS];
  logic [BITSIZE:0] word_pr [RS];   // {sat, sign, magnitude}

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RS; i++) begin
        vld_pr[i]  <= 1'b0;
        word_pr[i] <= '0;
      end
    end else if (en) begin
      vld_pr[0] <= res_vld;
      if (res_vld) begin
        word_pr[0] <= res_word;
      end
      for (int i = 1; i < RS; i++) begin
        vld_pr[i] <= vld_pr[i-1];
        if (vld_pr[i-1]) begin
          word_pr[i] <= word_pr[i-1];
        end
      end
    end
  end

  assign out_valid      = vld_pr[RS-1];
  assign {out_sat, c}   = word_pr[RS-1];

  // ---- saturation counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (clear_count) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && out_sat && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_smmul_pipe.sv
`timescale 1ns/1ps
// Testbench for smmul_pipe (BITSIZE=20, FRAC=11, LAT=3, CNTW=16).
// Directed vectors with hand-computed products; honours SMMUL_ROUND_EN.
module tb_smmul_pipe;

  localparam int BITSIZE = 20;
  localparam int FRAC    = 11;
  localparam int LAT     = 3;
  localparam int CNTW    = 16;

`ifdef SMMUL_ROUND_EN
  localparam logic [19:0] ROUND_C = 20'h00001;
`else
  localparam logic [19:0] ROUND_C = 20'h00000;
`endif

  // Stream vectors: a, b, expected c, expected sat.
  localparam logic [19:0] SA [10] = '{20'h00C00, 20'h80C00, 20'h01000, 20'h80800, 20'h00400,
                                      20'h88000, 20'h80001, 20'h02000, 20'h7FFFF, 20'h00000};
  localparam logic [19:0] SB [10] = '{20'h00C00, 20'h00C00, 20'h81800, 20'h80800, 20'h00400,
                                      20'h08000, 20'h00001, 20'h82000, 20'h00800, 20'h80C00};
  localparam logic [19:0] SC [10] = '{20'h01200, 20'h81200, 20'h83000, 20'h00800, 20'h00200,
                                      20'hFFFFF, 20'h00000, 20'h88000, 20'h7FFFF, 20'h00000};
  localparam logic        SS [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                      1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [19:0]       a = '0;
  logic [19:0]       b = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [19:0]       c;
  logic              out_sat;
  logic              clear_count = 1'b0;
  logic [CNTW-1:0]   sat_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  smmul_pipe #(
    .BITSIZE(BITSIZE),
    .FRAC   (FRAC),
    .LAT    (LAT),
    .CNTW   (CNTW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .c          (c),
    .out_sat    (out_sat),
    .clear_count(clear_count),
    .sat_count  (sat_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Ideal saturation decision from integer arithmetic on the magnitudes.
  function automatic logic ideal_sat(input logic [19:0] x, input logic [19:0] y);
    longint p;
    longint q;
    p = longint'(x[18:0]) * longint'(y[18:0]);
`ifdef SMMUL_ROUND_EN
    q = (p + (longint'(1) << (FRAC - 1))) >>> FRAC;
`else
    q = p >>> FRAC;
`endif
    return (q > longint'(20'h7FFFF));
  endfunction

  // One isolated transaction: latency, product and flag; optional clear
  // asserted in the cycle the result is transferred.
  task automatic run_one(input string tag, input logic [19:0] va, input logic [19:0] vb,
                         input logic [19:0] ec, input logic es, input logic clr);
    int n;
    @(negedge clk);
    a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, LAT);
    chk({tag, "_c"}, c, ec);
    chk({tag, "_sat"}, out_sat, es);
    clear_count = clr;
    @(negedge clk);
    clear_count = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int sent;
    int recv;
    int cyc;
    int stale;
    logic        held;
    logic [20:0] held_w;

    // Reset state
    out_ready = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c", c, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_sat_count", sat_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Directed products
    run_one("mul_1p5", 20'h00C00, 20'h00C00, 20'h01200, 1'b0, 1'b0);
    run_one("mul_neg", 20'h80C00, 20'h00C00, 20'h81200, 1'b0, 1'b0);
    run_one("neg_zero", 20'h80001, 20'h00001, 20'h00000, 1'b0, 1'b0);
    run_one("round", 20'h00001, 20'h00400, ROUND_C, 1'b0, 1'b0);
    run_one("max_x1", 20'h7FFFF, 20'h00800, 20'h7FFFF, ideal_sat(20'h7FFFF, 20'h00800), 1'b0);
    run_one("rnd_carry", 20'h40100, 20'h00FFC, 20'h7FFFF, ideal_sat(20'h40100, 20'h00FFC), 1'b0);

    // Saturation counter
    @(negedge clk); clear_count = 1'b1;
    @(negedge clk); clear_count = 1'b0;
    chk("cnt_cleared", sat_count, 0);
    run_one("ovf1", 20'h88000, 20'h08000, 20'hFFFFF, 1'b1, 1'b0);
    run_one("ovf2", 20'h88000, 20'h08000, 20'hFFFFF, 1'b1, 1'b0);
    chk("cnt_two", sat_count, 2);
    run_one("ovf3_clr", 20'h88000, 20'h08000, 20'hFFFFF, 1'b1, 1'b1);
    chk("cnt_clear_wins", sat_count, 0);

    // Back-to-back stream with random backpressure
    sent = 0; recv = 0; cyc = 0; held = 1'b0; held_w = '0;
    while (recv < 10 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (held) chk("stall_hold", {out_valid, out_sat, c}, {1'b1, held_w});
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 10) begin
        a = SA[sent]; b = SB[sent]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      held   = out_valid && !out_ready;
      held_w = {out_sat, c};
      if (out_valid && out_ready) begin
        chk($sformatf("stream%0d_c", recv), c, SC[recv]);
        chk($sformatf("stream%0d_sat", recv), out_sat, SS[recv]);
        recv++;
      end
      if (in_valid && in_ready) sent++;
    end
    chk("stream_done", recv, 10);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_sat_count", sat_count, 1);

    // Reset with three results in flight
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      a = 20'h88000; b = 20'h08000; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", sat_count, 0);
    chk("mid_rst_c", c, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_out", stale, 0);
    run_one("post_rst", 20'h00C00, 20'h00C00, 20'h01200, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
